// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

  typedef enum logic {
    ST_COUNT  = 1'b0,
    ST_FROZEN = 1'b1
  } bank_state_e;

  localparam int DEF_NUM_CH   = 5;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_SATURATE = 1;

  localparam int CH_INST  = 0;
  localparam int CH_ICHIT = 1;
  localparam int CH_ICREQ = 2;
  localparam int CH_DCHIT = 3;
  localparam int CH_DCREQ = 4;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow flag; saturates or wraps at all-ones.
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  function automatic logic [CNT_W-1:0] next_value(input logic [CNT_W-1:0] cur);
    if (cur == MAX_VAL)
      return (SATURATE != 0) ? MAX_VAL : '0;
    return cur + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      value <= next_value(value);
      if (value == MAX_VAL)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of per-channel event counters plus a cycle counter, with halt-freeze
// control and a two-register read pipeline.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter  int NUM_CH   = DEF_NUM_CH,
  parameter  int CNT_W    = DEF_CNT_W,
  parameter  int SATURATE = DEF_SATURATE,
  localparam int IDX_W    = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_en,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              halt_i,
  input  logic              clear_i,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic              frozen
);

  bank_state_e      state;
  logic             counting;
  logic [NUM_CH:0]  inc;
  logic [CNT_W-1:0] cnt_val [NUM_CH+1];
  logic [NUM_CH:0]  cnt_ovf;
  logic [CNT_W-1:0] sel_data;
  logic             sel_ovf;
  logic             vld_p0;
  logic [CNT_W-1:0] data_p0;
  logic             ovf_p0;

  always_ff @(posedge clk) begin
    if (rst || clear_i)
      state <= ST_COUNT;
    else if (state == ST_COUNT && halt_i)
      state <= ST_FROZEN;
  end

  assign frozen   = (state == ST_FROZEN);
  assign counting = (state == ST_COUNT) && count_en;
  // Top slot is the cycle counter; it ticks on every counting cycle.
  assign inc      = counting ? {1'b1, event_i} : '0;

  for (genvar k = 0; k <= NUM_CH; k++) begin : g_cnt
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear_i),
      .inc   (inc[k]),
      .value (cnt_val[k]),
      .ovf   (cnt_ovf[k])
    );
  end

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int k = 0; k <= NUM_CH; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        sel_data = cnt_val[k];
        sel_ovf  = cnt_ovf[k];
      end
    end
  end

  // Stage p0: snapshot of the selected counter before this edge's update
  always_ff @(posedge clk) begin
    if (rst)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= rd_req;
  end

  always_ff @(posedge clk) begin
    data_p0 <= sel_data;
    ovf_p0  <= sel_ovf;
  end

  // Stage p1: response register, holds last data between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
    end else begin
      rd_valid <= vld_p0;
      if (vld_p0) begin
        rd_data <= data_p0;
        rd_ovf  <= ovf_p0;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: saturating and wrapping 8-bit banks driven in
// parallel and compared against a true-event-count reference model.
module tb_perf_counter_bank;

  localparam int NCH = 5;

  logic           clk = 1'b0;
  logic           rst, count_en, halt_i, clear_i, rd_req;
  logic [NCH-1:0] event_i;
  logic [2:0]     rd_idx;
  logic           rd_valid_a, rd_ovf_a, frozen_a;
  logic           rd_valid_b, rd_ovf_b, frozen_b;
  logic [7:0]     rd_data_a, rd_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  int true_cnt [NCH+1];
  bit m_frozen;
  bit p_vld, e_vld;
  int p_cnt, e_cnt;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .count_en(count_en), .event_i(event_i),
    .halt_i(halt_i), .clear_i(clear_i), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_ovf(rd_ovf_a), .frozen(frozen_a)
  );

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .count_en(count_en), .event_i(event_i),
    .halt_i(halt_i), .clear_i(clear_i), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_ovf(rd_ovf_b), .frozen(frozen_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_v(input int c);
    return (c > 255) ? 255 : c;
  endfunction

  function automatic int wrap_v(input int c);
    return c % 256;
  endfunction

  function automatic int ov(input int c);
    return (c > 255) ? 1 : 0;
  endfunction

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic step();
    int snap;
    snap = (rd_idx <= 3'(NCH)) ? true_cnt[rd_idx] : 0;
    @(posedge clk);
    if (rst) begin
      e_vld = 0; e_cnt = 0; p_vld = 0; m_frozen = 0;
      foreach (true_cnt[k]) true_cnt[k] = 0;
    end else begin
      e_vld = p_vld;
      if (p_vld) e_cnt = p_cnt;
      p_vld = rd_req;
      p_cnt = snap;
      if (clear_i) begin
        foreach (true_cnt[k]) true_cnt[k] = 0;
        m_frozen = 0;
      end else if (!m_frozen) begin
        if (count_en) begin
          true_cnt[NCH]++;
          for (int k = 0; k < NCH; k++) if (event_i[k]) true_cnt[k]++;
        end
        if (halt_i) m_frozen = 1;
      end
    end
    #1;
    chk("rd_valid_sat",  32'(rd_valid_a), 32'(e_vld));
    chk("rd_valid_wrap", 32'(rd_valid_b), 32'(e_vld));
    chk("frozen_sat",    32'(frozen_a),   32'(m_frozen));
    chk("frozen_wrap",   32'(frozen_b),   32'(m_frozen));
    chk("rd_data_sat",   32'(rd_data_a),  32'(sat_v(e_cnt)));
    chk("rd_ovf_sat",    32'(rd_ovf_a),   32'(ov(e_cnt)));
    chk("rd_data_wrap",  32'(rd_data_b),  32'(wrap_v(e_cnt)));
    chk("rd_ovf_wrap",   32'(rd_ovf_b),   32'(ov(e_cnt)));
  endtask

  task automatic idle_inputs();
    rst = 0; count_en = 0; halt_i = 0; clear_i = 0; rd_req = 0;
    event_i = '0; rd_idx = '0;
  endtask

  task automatic rd(input logic [2:0] idx, input int ea, input int oa, input int eb, input int ob);
    rd_req = 1; rd_idx = idx;
    step();
    rd_req = 0;
    step();
    chk("read_valid", 32'(rd_valid_a), 32'd1);
    chk("read_sat",   32'(rd_data_a),  32'(ea));
    chk("read_ovf_s", 32'(rd_ovf_a),   32'(oa));
    chk("read_wrap",  32'(rd_data_b),  32'(eb));
    chk("read_ovf_w", 32'(rd_ovf_b),   32'(ob));
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    chk("reset_data", 32'(rd_data_a), 32'd0);
    chk("reset_frozen", 32'(frozen_a), 32'd0);
    rst = 0;

    // 20 counting cycles, ch0 on every other cycle, halt on the last
    count_en = 1;
    for (int i = 0; i < 20; i++) begin
      event_i = (i % 2 == 1) ? 5'b00001 : 5'b00000;
      halt_i  = (i == 19);
      step();
    end
    halt_i = 0; event_i = '0;
    chk("halt_frozen", 32'(frozen_a), 32'd1);
    rd(3'd0, 10, 0, 10, 0);
    rd(3'd5, 20, 0, 20, 0);

    // frozen bank ignores events and cycles
    event_i = 5'b11111;
    for (int i = 0; i < 50; i++) step();
    event_i = '0;
    rd(3'd0, 10, 0, 10, 0);
    rd(3'd5, 20, 0, 20, 0);
    count_en = 0;
    clear_i = 1; step(); clear_i = 0;
    chk("clear_unfreeze", 32'(frozen_a), 32'd0);
    rd(3'd0, 0, 0, 0, 0);
    rd(3'd5, 0, 0, 0, 0);
    count_en = 1; event_i = 5'b00001;
    for (int i = 0; i < 3; i++) step();
    count_en = 0; event_i = '0;
    rd(3'd0, 3, 0, 3, 0);
    rd(3'd5, 3, 0, 3, 0);

    // 300 events on ch1 in an 8-bit bank
    clear_i = 1; step(); clear_i = 0;
    count_en = 1; event_i = 5'b00010;
    for (int i = 0; i < 300; i++) step();
    count_en = 0; event_i = '0;
    rd(3'd1, 255, 1, 44, 1);
    rd(3'd5, 255, 1, 44, 1);

    // back-to-back reads of every slot while counting
    count_en = 1;
    for (int i = 0; i <= NCH; i++) begin
      event_i = 5'($urandom);
      rd_req = 1; rd_idx = 3'(i);
      step();
    end
    rd_req = 0; count_en = 0; event_i = '0;
    step(); step();

    // clear wins over same-cycle event and halt
    count_en = 1; event_i = 5'b00100;
    for (int i = 0; i < 3; i++) step();
    clear_i = 1; halt_i = 1;
    step();
    clear_i = 0; halt_i = 0; count_en = 0; event_i = '0;
    chk("clear_over_halt", 32'(frozen_a), 32'd0);
    rd(3'd2, 0, 0, 0, 0);
    rd(3'd7, 0, 0, 0, 0);

    // reset the cycle after a read request drops the response
    count_en = 1; event_i = 5'b11111;
    for (int i = 0; i < 4; i++) step();
    count_en = 0; event_i = '0;
    rd_req = 1; rd_idx = 3'd0; step();
    rd_req = 0; rst = 1; step();
    chk("rst_no_valid", 32'(rd_valid_a), 32'd0);
    rst = 0; step();
    chk("rst_no_valid_late", 32'(rd_valid_a), 32'd0);
    rd(3'd0, 0, 0, 0, 0);
    rd(3'd5, 0, 0, 0, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      count_en = ($urandom_range(0, 3) != 0);
      event_i  = 5'($urandom);
      halt_i   = count_en && ($urandom_range(0, 99) < 3);
      clear_i  = ($urandom_range(0, 99) < 2);
      rd_req   = $urandom_range(0, 1) == 1;
      rd_idx   = 3'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 999) < 5);
      step();
    end
    idle_inputs();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 5, number of event channels (1..16).
REQ-002 Parameter CNT_W, default 32, counter width in bits (8..64).
REQ-003 Parameter SATURATE, default 1; 1 = saturate at max, 0 = wrap to zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 count_en  input  1  global count qualifier (core out of reset / running).
REQ-007 event_i  input  NUM_CH  per-channel event strobes, one count per high cycle.
REQ-008 halt_i  input  1  processor halt strobe; freezes the bank.
REQ-009 clear_i  input  1  zero all counters and overflow flags, unfreeze.
REQ-010 rd_req  input  1  read request, one per cycle max.
REQ-011 rd_idx  input  $clog2(NUM_CH+1)  counter select; index NUM_CH = cycle counter.
REQ-012 rd_valid  output  1  read response strobe.
REQ-013 rd_data  output  CNT_W  selected counter value.
REQ-014 rd_ovf  output  1  sticky overflow flag of selected counter.
REQ-015 frozen  output  1  high while bank is in FROZEN state.

Function
REQ-016 Bank SHALL hold NUM_CH event counters plus one cycle counter, each CNT_W bits with a sticky overflow flag.
REQ-017 State machine SHALL have two states: COUNT and FROZEN; frozen = (state == FROZEN).
REQ-018 In COUNT with count_en=1: cycle counter +1 every cycle; event counter k +1 when event_i[k]=1.
REQ-019 In COUNT with count_en=0: no counter changes.
REQ-020 halt_i=1 in COUNT with count_en=1: that cycle's events and cycle SHALL be counted, then state -> FROZEN next edge.
REQ-021 In FROZEN: no counter or flag changes; halt_i ignored.
REQ-022 clear_i=1 (either state): all counters and flags -> 0, state -> COUNT; clear SHALL take priority over same-cycle events and halt_i.
REQ-023 Increment from all-ones with SATURATE=1: value holds all-ones, ovf set.
REQ-024 Increment from all-ones with SATURATE=0: value -> 0, ovf set.
REQ-025 Overflow flags SHALL be sticky until clear_i or rst.
REQ-026 rd_req sampled at edge N SHALL give rd_valid=1 for exactly one cycle after edge N+1, with rd_data/rd_ovf equal to the selected counter's value before edge N's update (1-cycle latency).
REQ-027 Back-to-back rd_req SHALL yield one response per cycle, in order, no stalls.
REQ-028 Reads SHALL be serviced in both states and SHALL NOT alter counters.
REQ-029 rd_idx > NUM_CH SHALL return rd_valid=1, rd_data=0, rd_ovf=0.
REQ-030 rd_data and rd_ovf SHALL hold their last value when rd_valid=0.
REQ-031 rd_req coincident with clear_i SHALL return pre-clear value.

Reset
REQ-032 rst=1 SHALL set all counters and flags to 0, state COUNT, rd_valid=0, rd_data=0, rd_ovf=0, frozen=0 at the next edge.
REQ-033 rst asserted mid-read SHALL suppress the pending response (no rd_valid after reset).
REQ-034 rst SHALL dominate clear_i, halt_i, rd_req.

Structure
REQ-035 Shared package perf_pkg SHALL hold the state enum, default parameter values, and channel index constants CH_INST=0, CH_ICHIT=1, CH_ICREQ=2, CH_DCHIT=3, CH_DCREQ=4.
REQ-036 One sub-module perf_counter (CNT_W counter, SATURATE mode, inc/clr inputs, sticky ovf) SHALL be instantiated NUM_CH+1 times.
REQ-037 Read mux and response register SHALL live in perf_counter_bank.

Verification
REQ-038 Reset, count_en=1, event_i[0] high 10 of 20 cycles, halt on cycle 20 -> idx0 reads 10, idx NUM_CH reads 20, frozen=1.
REQ-039 CNT_W=8, SATURATE=1, 300 events ch1 -> rd_data=0xFF, rd_ovf=1; SATURATE=0 -> rd_data=300-256=44, rd_ovf=1.
REQ-040 After freeze, 50 more events and cycles -> all reads unchanged; clear_i -> all reads 0, frozen=0, counting resumes.
REQ-041 rd_req on 6 consecutive cycles idx 0..5 (NUM_CH=5) -> 6 consecutive rd_valid pulses, idx5 = cycle count, in order.
REQ-042 clear_i and event_i[2] and halt_i same cycle -> ch2 reads 0, frozen=0; rd_idx=7 -> rd_data=0, rd_ovf=0.
REQ-043 rst asserted cycle after rd_req -> no rd_valid, all reads 0 after reset.
